// File: rtl/mnist_pkg.sv
// Shared types and constants for the Net result stage (state encoding, BCD limits, defaults).
package mnist_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_MARGIN,
    ST_CONVERT,
    ST_DONE
  } state_t;

  localparam int CONF_SAT_BCD    = 9999;
  localparam int BCD_STEPS       = 14;
  localparam int NUM_CLASSES_DEF = 10;
  localparam int SCORE_W_DEF     = 16;
endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (double dabble), one step per clock.
module bin2bcd_seq
  import mnist_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [13:0] bin,
  output logic [15:0] bcd,
  output logic        done
);
  logic [15:0] bcd_q, bcd_d, adj;
  logic [13:0] sh_q, sh_d;
  logic [3:0]  cnt_q, cnt_d;

  always_comb begin
    adj   = '0;
    bcd_d = bcd_q;
    sh_d  = sh_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++)
      adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
    if (load) begin
      bcd_d = '0;
      sh_d  = bin;
      cnt_d = '0;
    end else if (cnt_q != 4'(BCD_STEPS)) begin
      {bcd_d, sh_d} = {adj, sh_q} << 1;
      cnt_d         = cnt_q + 4'd1;
    end
  end

  // Counter parks at BCD_STEPS so an idle converter reads as done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_q <= '0;
      sh_q  <= '0;
      cnt_q <= 4'(BCD_STEPS);
    end else begin
      bcd_q <= bcd_d;
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign bcd  = bcd_q;
  assign done = (cnt_q == 4'(BCD_STEPS));
endmodule

// File: rtl/score_argmax.sv
// Argmax + confidence margin over a stream of class scores, formatted for segDisplay.
// Define SCORE_ARGMAX_BCD_EN to get BCD confidence; otherwise confidence is binary.
module score_argmax
  import mnist_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int SCORE_W     = SCORE_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      score_valid,
  input  logic signed [SCORE_W-1:0] score,
  input  logic                      score_last,
  output logic                      score_ready,
  output logic                      busy,
  output logic                      result_valid,
  output logic [3:0]                digit,
  output logic [15:0]               confidence
);
  localparam int CW = $clog2(NUM_CLASSES + 1);
`ifdef SCORE_ARGMAX_BCD_EN
  localparam logic [SCORE_W:0] SAT = (SCORE_W+1)'(CONF_SAT_BCD);
`else
  localparam logic [SCORE_W:0] SAT = (SCORE_W+1)'(16'hFFFF);
`endif

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic signed [SCORE_W-1:0] best_q, best_d, sec_q, sec_d;
  logic [3:0]                bidx_q, bidx_d;
  logic [3:0]                digit_q, digit_d;
  logic [15:0]               conf_q, conf_d;
  logic                      rv_q, rv_d;
  logic                      hs;
  logic [SCORE_W:0]          diff;
  logic [15:0]               margin;

`ifdef SCORE_ARGMAX_BCD_EN
  logic        conv_load, conv_done;
  logic [15:0] conv_bcd;

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .reset (reset),
    .load  (conv_load),
    .bin   (margin[13:0]),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );
`else
  logic [15:0] margin_q, margin_d;
  logic        mrg_q, mrg_d;
`endif

  // best >= second always holds, so the sign-extended difference is a valid unsigned margin.
  always_comb begin
    diff = {best_q[SCORE_W-1], best_q} - {sec_q[SCORE_W-1], sec_q};
    if (cnt_q == CW'(1))  margin = 16'(CONF_SAT_BCD);
    else if (diff > SAT)  margin = 16'(SAT);
    else                  margin = 16'(diff);
  end

  assign hs = score_valid && (state_q == ST_SCAN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    best_d  = best_q;
    sec_d   = sec_q;
    bidx_d  = bidx_q;
    digit_d = digit_q;
    conf_d  = conf_q;
    rv_d    = 1'b0;
`ifdef SCORE_ARGMAX_BCD_EN
    conv_load = 1'b0;
`else
    margin_d = margin_q;
    mrg_d    = mrg_q;
`endif
    if (start) begin
      state_d = ST_SCAN;
      cnt_d   = '0;
      best_d  = '0;
      sec_d   = '0;
      bidx_d  = '0;
`ifndef SCORE_ARGMAX_BCD_EN
      mrg_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_SCAN: if (hs) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == '0) begin
            best_d = score;
            bidx_d = '0;
          end else if (score > best_q) begin
            sec_d  = best_q;
            best_d = score;
            bidx_d = 4'(cnt_q);
          end else if (cnt_q == CW'(1) || score > sec_q) begin
            sec_d = score;
          end
          if (score_last || cnt_q == CW'(NUM_CLASSES - 1)) state_d = ST_MARGIN;
        end
`ifdef SCORE_ARGMAX_BCD_EN
        ST_MARGIN: begin
          conv_load = 1'b1;
          state_d   = ST_CONVERT;
        end
        ST_CONVERT: if (conv_done) begin
          state_d = ST_DONE;
          rv_d    = 1'b1;
          digit_d = bidx_q;
          conf_d  = conv_bcd;
        end
`else
        // Margin is registered first, then published, keeping the two-edge latency.
        ST_MARGIN: if (!mrg_q) begin
          mrg_d    = 1'b1;
          margin_d = margin;
        end else begin
          mrg_d   = 1'b0;
          state_d = ST_DONE;
          rv_d    = 1'b1;
          digit_d = bidx_q;
          conf_d  = margin_q;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      best_q  <= '0;
      sec_q   <= '0;
      bidx_q  <= '0;
      digit_q <= '0;
      conf_q  <= '0;
      rv_q    <= 1'b0;
`ifndef SCORE_ARGMAX_BCD_EN
      margin_q <= '0;
      mrg_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      best_q  <= best_d;
      sec_q   <= sec_d;
      bidx_q  <= bidx_d;
      digit_q <= digit_d;
      conf_q  <= conf_d;
      rv_q    <= rv_d;
`ifndef SCORE_ARGMAX_BCD_EN
      margin_q <= margin_d;
      mrg_q    <= mrg_d;
`endif
    end
  end

  assign score_ready  = (state_q == ST_SCAN);
  assign busy         = (state_q == ST_SCAN) || (state_q == ST_MARGIN) || (state_q == ST_CONVERT);
  assign result_valid = rv_q;
  assign digit        = digit_q;
  assign confidence   = conf_q;
endmodule

// File: tb/tb_score_argmax.sv
// Table-driven bench for score_argmax with a result scoreboard; adapts to SCORE_ARGMAX_BCD_EN.
module tb_score_argmax;
  localparam int SW = 16;
`ifdef SCORE_ARGMAX_BCD_EN
  localparam int LAT = 16;
  localparam bit BCD = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit BCD = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, score_valid = 1'b0, score_last = 1'b0;
  logic signed [SW-1:0] score = '0;
  logic        score_ready, busy, result_valid;
  logic [3:0]  digit;
  logic [15:0] confidence;

  typedef struct packed { logic [3:0] d; logic [15:0] c; } res_t;
  typedef struct { int n; bit lst; logic [3:0] d; logic [15:0] cb; logic [15:0] cn; } vec_t;

  vec_t vt[8];
  int   sc[8][16];
  res_t q[$];
  res_t last_res, mon_r;
  int   total = 0, passed = 0, pulses = 0, pushes = 0;

  score_argmax dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .score_valid  (score_valid),
    .score        (score),
    .score_last   (score_last),
    .score_ready  (score_ready),
    .busy         (busy),
    .result_valid (result_valid),
    .digit        (digit),
    .confidence   (confidence)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (result_valid) begin
      pulses++;
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_result: got digit %0h conf %0h expected no pulse", digit, confidence);
      end else begin
        mon_r = q.pop_front();
        chk("digit", digit, mon_r.d);
        chk("confidence", confidence, mon_r.c);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_scores(input int k);
    for (int i = 0; i < vt[k].n; i++) begin
      score       = SW'(sc[k][i]);
      score_valid = 1'b1;
      score_last  = vt[k].lst && (i == vt[k].n - 1);
      @(posedge clk); #1;
    end
    score_valid = 1'b0;
    score_last  = 1'b0;
  endtask

  task automatic push_exp(input int k);
    res_t e;
    e.d = vt[k].d;
    e.c = BCD ? vt[k].cb : vt[k].cn;
    q.push_back(e);
    pushes++;
    last_res = e;
  endtask

  // Called right after the last-handshake edge; counts edges until result_valid is seen.
  task automatic wait_result(input string nm);
    int edges = 0;
    while (edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (result_valid) break;
    end
    chk({nm, "_latency"}, edges, LAT);
    chk({nm, "_busy_done"}, busy, 1'b0);
    @(posedge clk); #1;
    chk({nm, "_rv_one_cycle"}, result_valid, 1'b0);
  endtask

  task automatic run_vec(input int k);
    pulse_start();
    chk("ready_after_start", score_ready, 1'b1);
    chk("busy_scan", busy, 1'b1);
    drive_scores(k);
    push_exp(k);
    wait_result($sformatf("vec%0d", k));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    sc[0] = '{5, -3, 100, 40, 0, 7, 99, 1, 2, 60, 0, 0, 0, 0, 0, 0};
    vt[0] = '{10, 1'b1, 4'd2, 16'h0001, 16'h0001};
    sc[1] = '{0, 0, 0, 0, 300, 0, 0, 0, 300, 0, 0, 0, 0, 0, 0, 0};
    vt[1] = '{10, 1'b0, 4'd4, 16'h0000, 16'h0000};
    sc[2] = '{20000, -20000, -20000, -20000, -20000, -20000, -20000, -20000, -20000, -20000, 0, 0, 0, 0, 0, 0};
    vt[2] = '{10, 1'b0, 4'd0, 16'h9999, 16'h9C40};
    sc[3] = '{10, 50, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[3] = '{3, 1'b1, 4'd1, 16'h0030, 16'h001E};
    sc[4] = '{42, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[4] = '{1, 1'b1, 4'd0, 16'h9999, 16'h270F};
    sc[5] = '{-100, -50, -200, -7, -9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[5] = '{5, 1'b1, 4'd3, 16'h0002, 16'h0002};
    sc[6] = '{1000, 900, 950, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[6] = '{3, 1'b1, 4'd0, 16'h0050, 16'h0032};
    sc[7] = '{1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[7] = '{2, 1'b1, 4'd0, 16'h1234, 16'h04D2};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", score_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rv", result_valid, 1'b0);
    chk("rst_digit", digit, 4'd0);
    chk("rst_conf", confidence, 16'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 8; k++) run_vec(k);

    // Abort mid-scan; the restart cycle also carries a score that must be dropped.
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      score = 16'sd30000; score_valid = 1'b1;
      @(posedge clk); #1;
    end
    score = 16'sd32000; score_valid = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; score_valid = 1'b0;
    chk("abort_rv", result_valid, 1'b0);
    chk("abort_digit_kept", digit, last_res.d);
    chk("abort_conf_kept", confidence, last_res.c);
    chk("abort_ready", score_ready, 1'b1);
    drive_scores(0);
    push_exp(0);
    wait_result("abort");

    // Asynchronous reset after the margin edge, while conversion is in flight.
    pulse_start();
    drive_scores(7);
    @(posedge clk); #3;
    chk("pre_reset_busy", busy, 1'b1);
    chk("pre_reset_conf", confidence, last_res.c);
    reset = 1'b1;
    #1;
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_ready", score_ready, 1'b0);
    chk("async_rst_rv", result_valid, 1'b0);
    chk("async_rst_digit", digit, 4'd0);
    chk("async_rst_conf", confidence, 16'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_conf", confidence, 16'd0);
    run_vec(3);

    repeat (3) @(posedge clk);
    #1;
    chk("pulse_count", pulses, pushes);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/score_argmax.md
# score_argmax

Sequential result stage between the output layer of `Net` and `segDisplay`. It accepts the ten class scores one per cycle over a valid/ready stream and tracks the best and runner-up scores. It then computes a confidence margin, converts it to four BCD digits, and presents `digit`/`confidence` in the format `segDisplay` already consumes (for example, confidence 0x0123 displays "123").

## Interface
- `NUM_CLASSES`, 10: scores per inference; maximum 16.
- `SCORE_W`, 16: width of a signed two's-complement score.
- `clk`  in  1: system clock; all state updates on rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle pulse that begins a new inference scan.
- `score_valid`  in  1: `score` is valid this cycle.
- `score`  in  SCORE_W: signed class score; class index is implicit arrival order, starting at 0.
- `score_last`  in  1: marks the final score of a scan.
- `score_ready`  out  1: block accepts a score this cycle.
- `busy`  out  1: high in every state except IDLE and DONE.
- `result_valid`  out  1: one-cycle pulse when `digit`/`confidence` update.
- `digit`  out  4: index of the winning class.
- `confidence`  out  16: margin between best and runner-up; four BCD digits, `[15:12]` thousands.

## Operation
- States: IDLE, SCAN, MARGIN, CONVERT, DONE.
- Reset values: all outputs 0 and state IDLE.
- IDLE/DONE -> SCAN on `start`. Entering SCAN clears the index counter and the best/second registers.
- SCAN:
  - `score_ready`=1.
  - A handshake is `score_valid && score_ready`.
  - The index counter increments on each handshake.
  - Strict-greater compare: ties keep the lower index. A beaten best moves to second.
- SCAN -> MARGIN on the handshake that carries `score_last`, or on the NUM_CLASSES-th handshake, whichever comes first.
- MARGIN:
  - Margin = best − second, computed as unsigned in SCORE_W+1 bits, then saturated to 9999.
  - If only one score was accepted, margin = 9999.
- CONVERT: 14-step shift-add-3 (double dabble) binary-to-BCD, one step per cycle.
- DONE:
  - On entry, `digit` and `confidence` are registered and `result_valid` pulses.
  - Outputs hold until the next `result_valid`.
- `start` in SCAN/MARGIN/CONVERT aborts the scan and restarts it. There is no `result_valid`, and previous outputs are kept.
- `score_valid` outside SCAN is ignored.
- `start` and a handshake in the same cycle: `start` wins and the score is dropped.

## Timing
- Throughput: one score per cycle in SCAN.
- The edge that samples the last score is E0.
  - MARGIN completes at E1.
  - CONVERT steps occur at E2..E15.
  - `result_valid`=1 during the cycle following E16, with new `digit`/`confidence` visible in the same cycle.
- `start` sampled at edge S: `score_ready`=1 from the cycle after S.
- Minimum `start`-to-`result_valid` for 10 back-to-back scores: 26 edges.
- Reset asserted mid-operation: immediate return to IDLE, outputs cleared to 0.

## Configuration
- `SCORE_ARGMAX_BCD_EN` defined:
  - BCD conversion is compiled in and `confidence` is BCD, as above.
  - Saturation limit is 9999.
- Not defined:
  - CONVERT state and converter are removed; DONE is entered directly after MARGIN.
  - `confidence` = binary margin saturated to 0xFFFF.
  - `result_valid` follows E2 instead of E16.

## Structure
- Shared package `mnist_pkg` holds:
  - state encoding;
  - `CONF_SAT_BCD` (9999) and `BCD_STEPS` (14);
  - default `NUM_CLASSES`/`SCORE_W`.
- One sub-module `bin2bcd_seq`, instantiated only under the macro:
  - ports: `clk`, `reset`, `load`, 14-bit `bin`;
  - outputs: `bcd[15:0]`, `done`;
  - fixed 14-cycle latency.

## Test plan
- Scores 5, −3, 100, 40, 0, 7, 99, 1, 2, 60 (last on 10th) -> `digit`=2, `confidence`=0x0001, one `result_valid` pulse exactly 16 edges after the last handshake.
- Scores all 0 except indices 4 and 8 = 300 -> tie resolves to `digit`=4, `confidence`=0x0000.
- Score 0 = 20000, score 1 = −20000, rest −20000 -> margin 40000 saturates -> `digit`=0, `confidence`=0x9999.
- `score_last` on the 3rd score (10, 50, 20) -> `digit`=1, `confidence`=0x0030. Single score with last -> `confidence`=0x9999.
- `start` re-pulsed mid-SCAN after 4 scores, then 10 new scores -> exactly one `result_valid`, reflecting only the new scores. Previous outputs unchanged during the abort.
- Reset asserted during CONVERT -> all outputs 0 in the same cycle (asynchronous). After release, a normal scan completes correctly.
